// File: rtl/hid_uart_rx_if.sv
// Receive-side byte interface: first-word-fall-through byte stream plus status pulses.
// Latency: wires only, no storage.
// Backpressure: the consumer holds rx_ready low to keep the head byte; the receiver never stalls the line.
interface hid_uart_rx_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          frame_err;
    logic          overrun;
    logic [CW-1:0] fifo_count;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, fifo_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, fifo_count,
        output rx_ready
    );
endinterface

// File: rtl/hid_uart_rx.sv
// Generic FWFT FIFO: head entry presented while non-empty, zero otherwise.
// Latency: write visible on rd_vld one cycle after the push.
// Backpressure: wr_rdy drops only when full with no pop in the same cycle.
module hid_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_rdy,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    input  logic                   rd_rdy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push, pop;

    // Handshake decode and pointer/occupancy update; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        rd_vld   = (count_q != '0);
        rd_dat   = rd_vld ? mem_q[rd_ptr_q] : '0;
        pop      = rd_vld && rd_rdy;
        wr_rdy   = (count_q != (AW+1)'(DEPTH)) || pop;
        push     = wr_vld && wr_rdy;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observable through rd_dat while non-empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign count = count_q;
endmodule

// 8N1 UART receiver with a small FWFT byte FIFO and registered error pulses.
// Latency: byte visible one cycle after the mid-stop-bit sample (2-flop sync plus ~9.5 bit times from start edge).
// Backpressure: line cannot be stalled; a good byte arriving at a full FIFO with no pop is dropped and flagged.
module hid_uart_rx #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          uart_rx,
    hid_uart_rx_if.master rx_if
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int CNTW = $clog2(CPB) + 1;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNTW-1:0] CNT_BIT  = CNTW'(CPB - 1);
    localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CPB / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [1:0]      sync_q, sync_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            push_vld, push_rdy, rx_s;
    logic [7:0]      head_dat;
    logic            head_vld;
    logic [CW-1:0]   count;

    assign rx_s = sync_q[1];

    // Framing FSM: mid-bit sampling, LSB-first shift, push or error decided at mid stop bit.
    always_comb begin
        sync_d      = {sync_q[0], uart_rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_vld    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_vld = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A good byte refused by the FIFO becomes an overrun pulse.
    assign overrun_d = push_vld && !push_rdy;

    // State, timing, synchronizer and error-pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync_q      <= 2'b11;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    hid_uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (push_vld),
        .wr_dat (shift_q),
        .wr_rdy (push_rdy),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .rd_rdy (rx_if.rx_ready),
        .count  (count)
    );

    assign rx_if.rx_data    = head_dat;
    assign rx_if.rx_valid   = head_vld;
    assign rx_if.fifo_count = count;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.overrun    = overrun_q;
endmodule

// File: doc/hid_uart_rx.md
HID_UART_RX -- requirements
Module: hid_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (104 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, at least 2.
REQ-004 SHALL have port clk  input  1  system clock (12 MHz USB clock domain).
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port rx_data  output  8  byte at the FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty; rx_data valid.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts the head byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer; only the synchronized value is used, adding 2 cycles of latency.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH, with a bit-timing counter and a 3-bit bit index.
REQ-015 In IDLE, a synchronized low SHALL move the FSM to START and clear the counter.
REQ-016 In START, the line SHALL be sampled when the counter reaches CLKS_PER_BIT/2-1: low -> DATA with counter cleared; high -> IDLE (glitch), with no output effect.
REQ-017 In DATA, the line SHALL be sampled each time the counter reaches CLKS_PER_BIT-1, after which the counter clears; bits are shifted in LSB first; after the 8th sample -> STOP.
REQ-018 In STOP, the line SHALL be sampled at CLKS_PER_BIT-1: high -> byte pushed, then IDLE in the next cycle (mid stop bit, for resync); low -> frame_err pulse, byte discarded, then WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL remain until the synchronized line is high, then go to IDLE; a break, or a line held low, yields exactly one frame_err.
REQ-020 The FIFO SHALL be first-word-fall-through: rx_valid = (fifo_count != 0); rx_data = head entry whenever rx_valid is 1.
REQ-021 A pop SHALL occur on any cycle where rx_valid && rx_ready; rx_ready while empty has no effect.
REQ-022 A push SHALL occur on the stop-sample cycle; rx_valid and the updated fifo_count are visible the next cycle.
REQ-023 Full handling: the full test SHALL use fifo_count before that cycle's pop, except that push and pop in the same cycle while full SHALL be accepted, leaving count unchanged.
REQ-024 A push while full without a pop SHALL drop the byte, pulse overrun for one cycle, and leave FIFO contents unchanged.
REQ-025 Simultaneous push and pop while non-full and non-empty SHALL leave fifo_count unchanged; while empty, push only.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-027 frame_err and overrun SHALL be registered, mutually exclusive per frame, and never high for more than one consecutive cycle per frame.

Reset
REQ-028 While resetn = 0, SHALL force the FSM to IDLE; counter, bit index and shift register to 0; synchronizer flops to 1; pointers and fifo_count to 0; rx_valid, frame_err and overrun to 0; rx_data to 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL restart only on a new falling edge, and a line already low SHALL be treated as a start.

Verification
REQ-030 Send 0xA5 at 104 clk/bit with rx_ready = 0 -> rx_valid = 1, rx_data = 0xA5, fifo_count = 1, within 10*104+4 cycles of the start edge; no error pulses.
REQ-031 Send a 20-cycle low glitch on an idle line -> no push, no frame_err, FSM back in IDLE; a following byte 0x3C is received correctly.
REQ-032 Send 0x3C with the stop bit low, then hold the line low for 500 cycles -> exactly one frame_err pulse, fifo_count = 0; the next byte 0x55 is received only after the line returns high.
REQ-033 Send 0x01..0x05 back-to-back with rx_ready = 0 -> fifo_count = 4, one overrun pulse on the 5th byte; draining yields 0x01, 0x02, 0x03, 0x04 in order.
REQ-034 With the FIFO full, hold rx_ready = 1 so a pop coincides with a push of 0x77 -> no overrun, fifo_count stays 4, and 0x77 is read last.
REQ-035 Assert resetn = 0 during bit 3 of a frame, release it, then send 0xC3 -> only 0xC3 is received, no frame_err.
